// File: rtl/rotate_pattern_capture.sv
// ============================================================================
//  Module      : rotate_pattern_capture
//  Description : Reassembles WIDTH-bit words from one serial line. The line
//                is sampled once per prescaler tick. Lock is flagged when two
//                consecutive completed words are equal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rotate_pattern_capture #(
  parameter int DIV   = 50000000,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     sin,
  output logic                     tick_out,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]         word,
  output logic                     word_valid,
  output logic                     locked
);

  localparam int PW = $clog2(DIV);
  localparam int BW = $clog2(WIDTH);
  localparam logic [PW-1:0] c_presc_last = PW'(DIV - 1);
  localparam logic [BW-1:0] c_bit_last   = BW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_next;
  logic             r_sync1;
  logic             r_sin_s;
  logic             r_tick_out;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_shifted;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic             r_prev_valid;
  logic             r_locked;
  logic             w_tick;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sin_s <= 1'b0;
    end else begin
      r_sync1 <= sin;
      r_sin_s <= r_sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and next prescaler value; arm always restarts the count
  always_comb begin
    w_state_next = r_state;
    w_presc_next = '0;
    case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!arm && (r_presc != c_presc_last)) begin
          w_presc_next = r_presc + PW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_tick    = (r_state == SHIFT) && (r_presc == c_presc_last);
  assign w_shifted = {r_sreg[WIDTH-2:0], r_sin_s};

  // Prescaler; tick_out is a flop loaded from the next-cycle tick condition so
  // that it is high in exactly the cycle where the tick is acted upon
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_tick_out <= 1'b0;
    end else begin
      r_presc    <= w_presc_next;
      r_tick_out <= (w_state_next == SHIFT) && (w_presc_next == c_presc_last);
    end
  end

  // Word assembly, completion strobe and lock tracking; arm beats a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_prev_valid <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (arm) begin
        r_sreg       <= '0;
        r_bit_cnt    <= '0;
        r_prev_valid <= 1'b0;
        r_locked     <= 1'b0;
      end else if (w_tick) begin
        r_sreg <= w_shifted;
        if (r_bit_cnt == c_bit_last) begin
          r_bit_cnt    <= '0;
          r_word       <= w_shifted;
          r_word_valid <= 1'b1;
          r_locked     <= r_prev_valid && (w_shifted == r_word);
          r_prev_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end
    end
  end

  assign tick_out   = r_tick_out;
  assign bit_cnt    = r_bit_cnt;
  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign locked     = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_rotate_pattern_capture.sv
// ============================================================================
//  Module      : tb_rotate_pattern_capture
//  Description : Directed self-checking bench for rotate_pattern_capture
//                (DIV=4, WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rotate_pattern_capture;

  logic       clk;
  logic       rst;
  logic       arm;
  logic       sin;
  logic       tick_out;
  logic [2:0] bit_cnt;
  logic [7:0] word;
  logic       word_valid;
  logic       locked;

  int n_checks;
  int n_fail;

  rotate_pattern_capture #(
    .DIV   (4),
    .WIDTH (8)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .sin        (sin),
    .tick_out   (tick_out),
    .bit_cnt    (bit_cnt),
    .word       (word),
    .word_valid (word_valid),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until tick_out is seen (bounded at 20)
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_out && n < 20);
  endtask

  // Streams w MSB-first, one bit per tick; sin is assumed to already carry
  // w[7]. After the last tick sin is set to nxt (first bit of the next word).
  task automatic send_word(input logic [7:0] w, input logic nxt, input logic exp_lock,
                           input string tag);
    int n;
    for (int i = 7; i >= 0; i--) begin
      wait_tick(n);
      check({tag, "_gap"}, n, (i == 7) ? 3 : 4);
      sin = (i > 0) ? w[i-1] : nxt;
    end
    @(negedge clk);
    check({tag, "_valid"},  {31'd0, word_valid}, 1);
    check({tag, "_word"},   {24'd0, word}, {24'd0, w});
    check({tag, "_locked"}, {31'd0, locked}, {31'd0, exp_lock});
    check({tag, "_bitcnt"}, {29'd0, bit_cnt}, 0);
  endtask

  task automatic arm_pulse();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  initial begin
    int         n;
    int         ticks;
    logic [7:0] acc;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    arm = 1'b0;
    sin = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tick",   {31'd0, tick_out}, 0);
    check("rst_word",   {24'd0, word}, 0);
    check("rst_valid",  {31'd0, word_valid}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_bitcnt", {29'd0, bit_cnt}, 0);
    rst = 1'b0;

    // Idle with sin toggling: nothing moves
    ticks = 0;
    acc   = '0;
    for (int i = 0; i < 100; i++) begin
      sin = ~sin;
      @(negedge clk);
      if (tick_out) ticks++;
      acc = acc | word | {3'd0, locked, word_valid, bit_cnt};
    end
    check("idle_ticks", ticks, 0);
    check("idle_outs",  {24'd0, acc}, 0);

    // 0xA5 twice (rotation of a fixed pattern), then 0x3C twice
    sin = 1'b1;
    arm_pulse();
    send_word(8'hA5, 1'b1, 1'b0, "w1");
    send_word(8'hA5, 1'b0, 1'b1, "w2");
    send_word(8'h3C, 1'b0, 1'b0, "w3");
    send_word(8'h3C, 1'b1, 1'b1, "w4");

    // Three ticks of a new word, then arm coincident with the third tick
    for (int j = 0; j < 3; j++) begin
      wait_tick(n);
      check("part_gap", n, (j == 0) ? 3 : 4);
    end
    check("part_bitcnt", {29'd0, bit_cnt}, 2);
    arm = 1'b1;
    sin = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    check("rearm_bitcnt", {29'd0, bit_cnt}, 0);
    check("rearm_locked", {31'd0, locked}, 0);
    check("rearm_word",   {24'd0, word}, 32'h3C);
    check("rearm_valid",  {31'd0, word_valid}, 0);
    check("rearm_tick",   {31'd0, tick_out}, 0);
    send_word(8'h5A, 1'b0, 1'b0, "w5");
    send_word(8'h5A, 1'b1, 1'b1, "w6");

    // Asynchronous reset mid-word while locked and tick_out high
    wait_tick(n);
    wait_tick(n);
    check("pre_rst_locked", {31'd0, locked}, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_tick",   {31'd0, tick_out}, 0);
    check("arst_word",   {24'd0, word}, 0);
    check("arst_locked", {31'd0, locked}, 0);
    check("arst_bitcnt", {29'd0, bit_cnt}, 0);
    check("arst_valid",  {31'd0, word_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tick_out) ticks++;
    end
    check("post_rst_ticks", ticks, 0);

    // Fresh arm after reset: first word never locks
    sin = 1'b1;
    arm_pulse();
    send_word(8'hFF, 1'b0, 1'b0, "w7");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rotate_pattern_capture.md
Name: rotate_pattern_capture

Overview:
- Receive-side counterpart of the rotating LED register.
- Samples one serial line (the MSB tap of a left-rotating 8-bit register) once per slow tick and reassembles 8-bit words.
- Flags lock when consecutive words match, i.e. the observed pattern is a stable rotation.
- Uses a single system clock; the slow rate is a clock-enable tick from an internal prescaler, not a derived clock.

Parameters:
DIV, 50000000, clk cycles per sample tick (≥2); 1 Hz at 50 MHz; prescaler width = clog2(DIV)
WIDTH, 8, bits per word (≥2)

Ports:
clk       input   1      system clock, all logic on rising edge
rst       input   1      asynchronous, active-high reset
arm       input   1      synchronous 1-cycle pulse: start/restart framing
sin       input   1      serial data, asynchronous to clk (synchronised internally)
tick_out  output  1      1-cycle pulse on each sample tick
bit_cnt   output  3      bits captured in current word (clog2(WIDTH) bits)
word      output  WIDTH  last completed word
word_valid output 1      1-cycle pulse when word updates
locked    output  1      last two completed words were equal

Behaviour:
- Reset (async, rst=1): FSM=IDLE. prescaler=0, sreg=0, bit_cnt=0, word=0, prev_valid=0, word_valid=0, locked=0, tick_out=0, sync flops=0.
- sin passes through a 2-flop synchroniser (sin_s); sin must be stable ≥3 clk before a tick to be captured.
- FSM IDLE: prescaler held at 0, no ticks. arm=1 → SHIFT.
- FSM SHIFT: prescaler counts 0..DIV-1 and wraps. tick = (prescaler==DIV-1). tick_out is registered and asserted the same cycle as tick.
  - First tick comes DIV cycles after the arm cycle.
- On tick in SHIFT: sreg <= {sreg[WIDTH-2:0], sin_s} (MSB-first assembly).
  - If bit_cnt != WIDTH-1: bit_cnt+1.
  - If bit_cnt == WIDTH-1: bit_cnt wraps to 0; word <= {sreg[WIDTH-2:0], sin_s}; word_valid=1 on the next cycle (registered with word); locked <= prev_valid && (new word == word); prev_valid <= 1.
- word_valid is high exactly 1 cycle per completed word, otherwise 0.
- locked holds its value between word completions.
- arm in SHIFT (restart) has priority over a coincident tick: the tick is discarded. Clears prescaler, sreg, bit_cnt, prev_valid, locked, word_valid. word retains its last value. FSM stays SHIFT.
- arm in IDLE: same clears, then enters SHIFT.
- No exit from SHIFT except rst.
- rst mid-word: all state cleared immediately; partial word discarded; returns to IDLE.
- Counters are unsigned and wrap modulo their width; no overflow flags.

Test Plan (DIV=4, WIDTH=8 in sim):
1. rst pulse, then 100 idle cycles with sin toggling → all outputs 0, no tick_out, FSM IDLE.
2. arm at cycle T; drive 0xA5 MSB-first, one bit per tick period → tick_out at T+4, T+8, …, T+32; word_valid at T+33 with word=0xA5, locked=0.
3. Continue the same 8-bit rotation for 8 more ticks → word_valid at T+65, word=0xA5, locked=1.
4. Switch stream to 0x3C → next word=0x3C, locked=0; following word=0x3C, locked=1.
5. arm after 3 ticks of a word, coincident with a tick → that tick dropped, bit_cnt=0, locked=0, word unchanged; next word_valid 33 cycles after arm with the fresh 8 bits.
6. Assert rst asynchronously between clock edges mid-word with locked=1 → all outputs 0 before the next edge; no ticks until a new arm.
